// File: rtl/fast_score_seq.sv
`default_nettype none
// ============================================================================
// Module      : fast_score_seq
// Description : Multi-cycle FAST corner scorer. Captures one candidate and
//               reduces the masked ring pixels LANES per beat, producing a
//               min-of-arc score or a thresholded saturating SAD score,
//               with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fast_score_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_PIXELS  = 16,
    parameter int LANES       = 4,
    parameter int SCORE_MODE  = 0,
    parameter int SCORE_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   is_corner,
    input  logic [DATA_WIDTH-1:0]  center_pixel,
    input  logic [DATA_WIDTH-1:0]  circle_pixel [0:NUM_PIXELS-1],
    input  logic [NUM_PIXELS-1:0]  bright_mask,
    input  logic [NUM_PIXELS-1:0]  dark_mask,
    input  logic [DATA_WIDTH-1:0]  threshold,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   score_bright,
    output logic                   busy
);

    localparam int c_BEATS  = NUM_PIXELS / LANES;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_BEAT_W-1:0]    c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [SCORE_WIDTH-1:0] c_SAT       = '1;
    // Min mode starts from the largest possible difference, sum mode from 0.
    localparam logic [SCORE_WIDTH-1:0] c_ACC_INIT  =
        (SCORE_MODE == 0) ? SCORE_WIDTH'({DATA_WIDTH{1'b1}}) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_BEAT_W-1:0]     r_beat;
    logic [SCORE_WIDTH-1:0]  r_acc;
    logic [SCORE_WIDTH-1:0]  w_acc_next;
    logic                    r_bright;
    logic [DATA_WIDTH-1:0]   r_center;
    logic [DATA_WIDTH-1:0]   r_thr;
    logic [DATA_WIDTH-1:0]   r_ring [0:NUM_PIXELS-1];
    logic [NUM_PIXELS-1:0]   r_mask;
    logic [DATA_WIDTH-1:0]   w_diff [0:LANES-1];

    logic                    w_accept;
    logic                    w_pick_bright;
    logic [NUM_PIXELS-1:0]   w_sel_mask;
    logic                    w_degenerate;

    // Bright polarity wins whenever any bright bit is set.
    assign w_accept      = in_valid && (r_state == S_IDLE);
    assign w_pick_bright = |bright_mask;
    assign w_sel_mask    = w_pick_bright ? bright_mask : dark_mask;
    assign w_degenerate  = !is_corner || (w_sel_mask == '0);

    assign score        = r_acc;
    assign score_bright = r_bright;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_degenerate ? S_OUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (r_beat == c_LAST_BEAT) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Absolute difference for each lane; the ring is shifted down every beat
    // so lane l always sees ring position beat*LANES+l at r_ring[l].
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_diff[l] = (r_ring[l] > r_center) ? (r_ring[l] - r_center)
                                                  : (r_center - r_ring[l]);
    end

    if (SCORE_MODE == 0) begin : g_min
        logic w_unused_thr;
        assign w_unused_thr = ^r_thr;

        // Running minimum over the masked lanes of this beat.
        always_comb begin
            w_acc_next = r_acc;
            for (int l = 0; l < LANES; l++) begin
                if (r_mask[l] && (SCORE_WIDTH'(w_diff[l]) < w_acc_next)) begin
                    w_acc_next = SCORE_WIDTH'(w_diff[l]);
                end
            end
        end
    end else begin : g_sum
        logic [SCORE_WIDTH:0] w_sum;

        // Saturating sum of the above-threshold excess of masked lanes.
        always_comb begin
            w_sum = {1'b0, r_acc};
            for (int l = 0; l < LANES; l++) begin
                if (r_mask[l] && (w_diff[l] > r_thr)) begin
                    w_sum = w_sum + (SCORE_WIDTH + 1)'(w_diff[l] - r_thr);
                    if (w_sum[SCORE_WIDTH]) begin
                        w_sum = {1'b0, c_SAT};
                    end
                end
            end
            w_acc_next = w_sum[SCORE_WIDTH-1:0];
        end
    end

    // Accumulator, beat counter and polarity; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat   <= '0;
            r_acc    <= '0;
            r_bright <= 1'b0;
        end else if (w_accept) begin
            r_beat   <= '0;
            r_acc    <= w_degenerate ? '0 : c_ACC_INIT;
            r_bright <= w_pick_bright && !w_degenerate;
        end else if (r_state == S_ACCUM) begin
            r_beat   <= r_beat + 1'b1;
            r_acc    <= w_acc_next;
        end
    end

    // Candidate payload: captured on accept, shifted one beat at a time.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_center <= center_pixel;
            r_thr    <= threshold;
            r_mask   <= w_sel_mask;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                r_ring[i] <= circle_pixel[i];
            end
        end else if (r_state == S_ACCUM) begin
            r_mask <= r_mask >> LANES;
            for (int i = 0; i < NUM_PIXELS - LANES; i++) begin
                r_ring[i] <= r_ring[i + LANES];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fast_score_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fast_score_seq
// Description : Directed self-checking bench for fast_score_seq. Four
//               instances cover min mode (LANES 4 and 16) and sum mode
//               (SCORE_WIDTH 12 and 8) sharing one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fast_score_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  iv;
    logic        is_corner;
    logic [7:0]  center;
    logic [7:0]  ring [0:15];
    logic [15:0] bmask;
    logic [15:0] dmask;
    logic [7:0]  thr;
    logic        out_ready;

    logic [3:0]  ov, ir, bsy, sb;
    logic [11:0] score_a, score_b, score_c;
    logic [7:0]  score_d;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fast_score_seq u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .is_corner(is_corner), .center_pixel(center), .circle_pixel(ring),
        .bright_mask(bmask), .dark_mask(dmask), .threshold(thr),
        .out_valid(ov[0]), .out_ready(out_ready), .score(score_a),
        .score_bright(sb[0]), .busy(bsy[0])
    );

    fast_score_seq #(.LANES(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .is_corner(is_corner), .center_pixel(center), .circle_pixel(ring),
        .bright_mask(bmask), .dark_mask(dmask), .threshold(thr),
        .out_valid(ov[1]), .out_ready(out_ready), .score(score_b),
        .score_bright(sb[1]), .busy(bsy[1])
    );

    fast_score_seq #(.SCORE_MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .is_corner(is_corner), .center_pixel(center), .circle_pixel(ring),
        .bright_mask(bmask), .dark_mask(dmask), .threshold(thr),
        .out_valid(ov[2]), .out_ready(out_ready), .score(score_c),
        .score_bright(sb[2]), .busy(bsy[2])
    );

    fast_score_seq #(.SCORE_MODE(1), .SCORE_WIDTH(8)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .is_corner(is_corner), .center_pixel(center), .circle_pixel(ring),
        .bright_mask(bmask), .dark_mask(dmask), .threshold(thr),
        .out_valid(ov[3]), .out_ready(out_ready), .score(score_d),
        .score_bright(sb[3]), .busy(bsy[3])
    );

    function automatic logic [11:0] sc(input int s);
        case (s)
            0:       return score_a;
            1:       return score_b;
            2:       return score_c;
            default: return {4'b0, score_d};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flat(input logic [7:0] c, input logic [7:0] fill);
        center    = c;
        is_corner = 1'b1;
        bmask     = 16'h0;
        dmask     = 16'h0;
        thr       = 8'd0;
        for (int i = 0; i < 16; i++) ring[i] = fill;
    endtask

    task automatic set_t1();
        set_flat(8'd100, 8'd100);
        ring[12] = 8'd140; ring[13] = 8'd130; ring[14] = 8'd125; ring[15] = 8'd120;
        bmask = 16'hF000;
        thr   = 8'd10;
    endtask

    task automatic set_t2();
        set_flat(8'd100, 8'd100);
        ring[0] = 8'd60; ring[1] = 8'd65; ring[2] = 8'd70; ring[3] = 8'd75;
        dmask = 16'h000F;
    endtask

    // Accept one candidate on instance sel, scramble the bus afterwards,
    // then count edges until out_valid and check the result.
    task automatic run(input int sel, input int exp_lat, input logic [11:0] exp_sc,
                       input logic exp_b, input string tag);
        int n;
        iv[sel] = 1'b1;
        tick();
        iv = 4'b0;
        center = 8'hA5; bmask = 16'h5A5A; dmask = 16'hFFFF; thr = 8'hFF;
        for (int i = 0; i < 16; i++) ring[i] = 8'h00;
        n = 0;
        while (!ov[sel] && n < 40) begin
            check({tag, "_inready"}, ir[sel], 0);
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_score"}, sc(sel), exp_sc);
        check({tag, "_bright"}, sb[sel], exp_b);
    endtask

    task automatic release_out(input int sel, input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, ov[sel], 0);
        check({tag, "_rel_ready"}, ir[sel], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iv = 4'b0; out_ready = 1'b0;
        set_flat(8'd0, 8'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            check("rst_valid", ov[s], 0);
            check("rst_ready", ir[s], 1);
            check("rst_busy",  bsy[s], 0);
            check("rst_score", sc(s), 0);
            check("rst_bright", sb[s], 0);
        end

        // Bright arc, min mode, LANES 4 and 16; sum mode t=10.
        set_t1(); run(0, 4, 12'd20, 1'b1, "t1_l4");  release_out(0, "t1_l4");
        set_t1(); run(1, 1, 12'd20, 1'b1, "t1_l16"); release_out(1, "t1_l16");
        set_t1(); run(2, 4, 12'd75, 1'b1, "t4_sum"); release_out(2, "t4_sum");

        // Dark arc.
        set_t2(); run(0, 4, 12'd25, 1'b0, "t2_l4");  release_out(0, "t2_l4");
        set_t2(); run(1, 1, 12'd25, 1'b0, "t2_l16"); release_out(1, "t2_l16");

        // Degenerate: not a corner, then corner with empty masks.
        set_t2(); is_corner = 1'b0; dmask = 16'h0;
        run(0, 0, 12'd0, 1'b0, "t3_nocorner"); release_out(0, "t3_nocorner");
        set_t1(); run(0, 4, 12'd20, 1'b1, "t3_pre"); release_out(0, "t3_pre");
        set_t1(); bmask = 16'h0;
        run(0, 0, 12'd0, 1'b0, "t3_nomask"); release_out(0, "t3_nomask");

        // Saturation at 8 bits; same stimulus fits in 12 bits.
        set_flat(8'd0, 8'd255); bmask = 16'hFFFF;
        run(3, 4, 12'd255, 1'b1, "t4_sat8"); release_out(3, "t4_sat8");
        set_flat(8'd0, 8'd255); bmask = 16'hFFFF;
        run(2, 4, 12'd4080, 1'b1, "t4_sum12"); release_out(2, "t4_sum12");

        // Backpressure with a stray in_valid during the stall.
        set_t1(); run(0, 4, 12'd20, 1'b1, "t5");
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                set_t2();
                is_corner = 1'b0;
                iv[0] = 1'b1;
            end
            tick();
            iv[0] = 1'b0;
            check("t5_hold_valid", ov[0], 1);
            check("t5_hold_score", sc(0), 20);
            check("t5_hold_bright", sb[0], 1);
            check("t5_hold_ready", ir[0], 0);
        end
        release_out(0, "t5");
        tick();
        check("t5_no_capture", ov[0], 0);
        tick();
        check("t5_no_capture2", ov[0], 0);

        // Reset during beat 2.
        set_t1();
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_valid", ov[0], 0);
        check("t6_rst_score", sc(0), 0);
        check("t6_rst_ready", ir[0], 1);
        check("t6_rst_busy", bsy[0], 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t6_no_stale", ov[0], 0);
        end

        // Both masks set: bright wins.
        set_t1();
        ring[0] = 8'd60; ring[1] = 8'd65; ring[2] = 8'd70; ring[3] = 8'd75;
        dmask = 16'h000F;
        run(0, 4, 12'd20, 1'b1, "t6_prio"); release_out(0, "t6_prio");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
